// File: rtl/rv_mem_responder.sv
// Word-array memory responder with a valid/ready request channel and a fixed-latency response.
// Optional RV_MEM_RAND_STALL_EN adds an LFSR-driven random extra wait per request.
module rv_mem_responder #(
   parameter int unsigned BIN_DIG     = 32,
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned LATENCY     = 2
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic               req_we,
   input  logic [BIN_DIG-1:0] req_addr,
   input  logic [BIN_DIG-1:0] req_wdata,
   input  logic [3:0]         req_be,
   output logic               resp_valid,
   input  logic               resp_ready,
   output logic [BIN_DIG-1:0] resp_rdata,
   output logic               resp_err
);
   localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
`ifdef RV_MEM_RAND_STALL_EN
   localparam int unsigned CNT_W = 5;
`else
   localparam int unsigned CNT_W = 4;
`endif

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic               lat_we;
   logic [BIN_DIG-1:0] lat_addr;
   logic [BIN_DIG-1:0] lat_wdata;
   logic [3:0]         lat_be;
   logic [BIN_DIG-1:0] mem [DEPTH_WORDS];

   logic               accept;
   logic [CNT_W-1:0]   wait_len;
   logic               enter_resp;
   logic               acc_we;
   logic [BIN_DIG-1:0] acc_addr;
   logic [BIN_DIG-1:0] acc_wdata;
   logic [3:0]         acc_be;
   logic [IDX_W-1:0]   acc_idx;
   logic               acc_err;
   logic [BIN_DIG-1:0] acc_rdata;

   assign accept = (state == IDLE) && req_valid && req_ready;

`ifdef RV_MEM_RAND_STALL_EN
   logic [7:0] lfsr;
   assign wait_len = CNT_W'(LATENCY) + CNT_W'(lfsr[1:0]);
`else
   assign wait_len = CNT_W'(LATENCY);
`endif

   // A zero-wait accept commits on its own edge, so it must use the live request fields.
   always_comb begin
      acc_we    = lat_we;
      acc_addr  = lat_addr;
      acc_wdata = lat_wdata;
      acc_be    = lat_be;
      if (state == IDLE) begin
         acc_we    = req_we;
         acc_addr  = req_addr;
         acc_wdata = req_wdata;
         acc_be    = req_be;
      end
   end

   assign enter_resp = !RST && ((accept && (wait_len == '0)) || ((state == WAIT) && (cnt == '0)));
   assign acc_idx    = acc_addr[IDX_W+1:2];
   assign acc_err    = (acc_addr[1:0] != 2'b00) || ((acc_addr >> (IDX_W + 2)) != '0);
   assign acc_rdata  = (acc_we || acc_err) ? '0 : mem[acc_idx];

   always_ff @(posedge CLK) begin
      if (enter_resp && acc_we && !acc_err) begin
         for (int i = 0; i < 4; i++) begin
            if (acc_be[i]) mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= IDLE;
         cnt        <= '0;
         req_ready  <= 1'b0;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
         lat_we     <= 1'b0;
         lat_addr   <= '0;
         lat_wdata  <= '0;
         lat_be     <= '0;
`ifdef RV_MEM_RAND_STALL_EN
         lfsr       <= 8'hA5;
`endif
      end else begin
         unique case (state)
            IDLE: begin
               if (accept) begin
                  req_ready <= 1'b0;
                  lat_we    <= req_we;
                  lat_addr  <= req_addr;
                  lat_wdata <= req_wdata;
                  lat_be    <= req_be;
`ifdef RV_MEM_RAND_STALL_EN
                  lfsr      <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
`endif
                  if (wait_len == '0) begin
                     state      <= RESP;
                     resp_valid <= 1'b1;
                     resp_rdata <= acc_rdata;
                     resp_err   <= acc_err;
                  end else begin
                     state <= WAIT;
                     cnt   <= wait_len - 1'b1;
                  end
               end else begin
                  req_ready <= 1'b1;
               end
            end
            WAIT: begin
               if (cnt == '0) begin
                  state      <= RESP;
                  resp_valid <= 1'b1;
                  resp_rdata <= acc_rdata;
                  resp_err   <= acc_err;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            RESP: begin
               if (resp_ready) begin
                  state      <= IDLE;
                  resp_valid <= 1'b0;
                  resp_rdata <= '0;
                  resp_err   <= 1'b0;
                  req_ready  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_rv_mem_responder.sv
// Directed bench for rv_mem_responder: scoreboarded responses, latency, backpressure, resets.
// Latency expectations follow an LFSR model when RV_MEM_RAND_STALL_EN is defined.
module tb_rv_mem_responder;
   localparam int unsigned LATENCY = 2;
   localparam int unsigned DEPTH   = 1024;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        req_valid = 1'b0, req_we = 1'b0, resp_ready = 1'b0;
   logic [31:0] req_addr = '0, req_wdata = '0;
   logic [3:0]  req_be = '0;
   logic        req_ready, resp_valid, resp_err;
   logic [31:0] resp_rdata;

   typedef struct {logic [31:0] rdata; logic err; int lat;} exp_t;
   exp_t        sb[$];
   logic [31:0] mdl [int];
   logic [7:0]  m_lfsr = 8'hA5;
   int          checks = 0, errors = 0;

   always #5 CLK = ~CLK;

   rv_mem_responder #(.BIN_DIG(32), .DEPTH_WORDS(DEPTH), .LATENCY(LATENCY)) dut (
      .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .resp_valid(resp_valid),
      .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic int next_wait();
      int w = LATENCY;
`ifdef RV_MEM_RAND_STALL_EN
      w = w + int'(m_lfsr[1:0]);
      m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
`endif
      return w;
   endfunction

   // Drive one request and push its expected response; leaves req_valid high in the accept cycle.
   task automatic send(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input bit track);
      exp_t e;
      int   n = 0;
      int   key = int'(addr >> 2);
      e.err   = (addr[1:0] != 2'b00) || (addr >= DEPTH * 4);
      e.rdata = '0;
      if (!e.err && !we) e.rdata = mdl.exists(key) ? mdl[key] : 'x;
      if (!e.err && we && track) begin
         logic [31:0] w = mdl.exists(key) ? mdl[key] : '0;
         for (int i = 0; i < 4; i++) if (be[i]) w[8*i +: 8] = wdata[8*i +: 8];
         mdl[key] = w;
      end
      @(negedge CLK);
      while (!req_ready && n < 50) begin @(negedge CLK); n++; end
      if (!req_ready) check("req_ready_timeout", {31'b0, req_ready}, 32'd1);
      e.lat     = next_wait() + 1;
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
      if (track) sb.push_back(e);
   endtask

   task automatic collect(input int hold);
      exp_t        e;
      int          cycles = 1;
      logic [31:0] rd;
      logic        er;
      @(negedge CLK);
      req_valid = 1'b0;
      while (!resp_valid && cycles < 60) begin @(negedge CLK); cycles++; end
      e = sb.pop_front();
      if (!resp_valid) begin
         check("resp_timeout", {31'b0, resp_valid}, 32'd1);
         return;
      end
      check("rdata", resp_rdata, e.rdata);
      check("err", {31'b0, resp_err}, {31'b0, e.err});
      check("latency", cycles, e.lat);
      rd = resp_rdata; er = resp_err;
      for (int k = 0; k < hold; k++) begin
         req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'hBADBAD00;
         req_be = 4'hF;
         @(negedge CLK);
         check("bp_valid", {31'b0, resp_valid}, 32'd1);
         check("bp_rdata", resp_rdata, rd);
         check("bp_err", {31'b0, resp_err}, {31'b0, er});
         check("bp_req_ready", {31'b0, req_ready}, 32'd0);
      end
      req_valid  = 1'b0;
      resp_ready = 1'b1;
      @(negedge CLK);
      resp_ready = 1'b0;
      check("post_valid", {31'b0, resp_valid}, 32'd0);
      check("post_req_ready", {31'b0, req_ready}, 32'd1);
   endtask

   initial begin
      @(negedge CLK);
      check("rst_req_ready", {31'b0, req_ready}, 32'd0);
      check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
      @(negedge CLK);
      check("rst_rdata", resp_rdata, 32'd0);
      check("rst_err", {31'b0, resp_err}, 32'd0);
      RST = 1'b0;
      @(negedge CLK);
      check("idle_req_ready", {31'b0, req_ready}, 32'd1);

      send(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b1); collect(0);
      send(1'b0, 32'h10, 32'h0, 4'h0, 1'b1);        collect(0);
      send(1'b1, 32'h10, 32'h11223344, 4'b0101, 1'b1); collect(0);
      send(1'b0, 32'h10, 32'h0, 4'h0, 1'b1);        collect(0);
      check("be_merge_model", mdl[4], 32'hDE22BE44);

      send(1'b1, 32'h0, 32'hCAFEF00D, 4'hF, 1'b1);  collect(0);
      send(1'b0, 32'h13, 32'h0, 4'h0, 1'b1);        collect(0);
      send(1'b1, 32'h1000, 32'h12345678, 4'hF, 1'b1); collect(0);
      send(1'b0, 32'h0, 32'h0, 4'h0, 1'b1);         collect(0);
      send(1'b1, 32'hFFC, 32'hA1B2C3D4, 4'hF, 1'b1); collect(0);
      send(1'b0, 32'hFFC, 32'h0, 4'h0, 1'b1);       collect(0);
      send(1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, 1'b1); collect(0);
      send(1'b0, 32'h10, 32'h0, 4'h0, 1'b1);        collect(5);
      send(1'b0, 32'h10, 32'h0, 4'h0, 1'b1);        collect(0);

      send(1'b1, 32'h20, 32'h01234567, 4'hF, 1'b1); collect(0);
      send(1'b1, 32'h20, 32'h55AA55AA, 4'hF, 1'b0);
      @(negedge CLK);
      req_valid = 1'b0;
      check("wait_resp_valid", {31'b0, resp_valid}, 32'd0);
      RST = 1'b1;
      @(negedge CLK);
      RST    = 1'b0;
      m_lfsr = 8'hA5;
      check("rst_wait_valid", {31'b0, resp_valid}, 32'd0);
      send(1'b0, 32'h20, 32'h0, 4'h0, 1'b1);        collect(0);
      send(1'b0, 32'h10, 32'h0, 4'h0, 1'b1);        collect(0);
      send(1'b0, 32'h0, 32'h0, 4'h0, 1'b1);         collect(0);
      send(1'b0, 32'hFFC, 32'h0, 4'h0, 1'b1);       collect(0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/rv_mem_responder.md
Name: rv_mem_responder

Overview:
Memory-side responder for the CPU's instruction-fetch and data-access request channels. It accepts one word-aligned read or write request at a time over a valid/ready handshake. It services the request from an internal word array after a configurable wait latency, then returns read data or a write acknowledgement on a response channel. It sits beside rv_cpu and is instantiated once for instruction memory and once for data memory.

Parameters:
BIN_DIG, 32, data and address width in bits (fixed to 32; byte enables are BIN_DIG/8 = 4)
DEPTH_WORDS, 1024, number of BIN_DIG-bit words in the array (power of two, at least 2)
LATENCY, 2, wait cycles between request acceptance and response valid (0 to 15)

Ports:
CLK  in  1  clock
RST  in  1  synchronous reset, active-high
req_valid  in  1  request present
req_ready  out  1  responder can accept a request
req_we  in  1  1 = write, 0 = read
req_addr  in  BIN_DIG  byte address
req_wdata  in  BIN_DIG  write data
req_be  in  4  byte enables for writes; bit i controls byte i (wdata[8i+7:8i])
resp_valid  out  1  response present
resp_ready  in  1  requester accepts response
resp_rdata  out  BIN_DIG  read data (0 for writes and errors)
resp_err  out  1  misaligned or out-of-range access

Behaviour:
- Reset: RST sampled on the CLK posedge and active-high, as already decided. Registered outputs clear: req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0. State goes to IDLE. Array contents are not cleared by reset.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready=1. On req_valid and req_ready at a posedge, latch we, addr, wdata and be. If LATENCY==0, go to RESP; otherwise load cnt=LATENCY-1 and go to WAIT.
  - WAIT: req_ready=0. Decrement cnt each cycle. When cnt==0, go to RESP.
  - RESP: resp_valid=1. resp_rdata and resp_err stay stable until resp_valid and resp_ready occur at a posedge. On that handshake go to IDLE; req_ready becomes 1 in the next cycle. There is no back-to-back accept in the handshake cycle.
- Acceptance-to-resp_valid latency is LATENCY+1 cycles.
- Commit: the array is accessed on the edge that enters RESP.
  - Read: resp_rdata = mem[idx].
  - Write: mem[idx] byte i updated where be[i]=1; resp_rdata=0.
- Index: idx = addr[log2(DEPTH_WORDS)+1:2].
- Error: resp_err=1 when addr[1:0]!=0 or addr>=DEPTH_WORDS*4. In that case there is no array update and resp_rdata=0.
- A write with be=0 is legal: no update, resp_err=0.
- Only one request is outstanding at a time. req_* inputs are ignored outside IDLE.
- Read-after-write to the same address on consecutive requests returns the new data.
- Reset during WAIT: the request is abandoned and its write is never committed.
- Reset during RESP: the response is dropped, even though a write has already been committed.
- resp_valid must never drop without a handshake, except on reset.

Optional Feature:
RV_MEM_RAND_STALL_EN
- Defined: an 8-bit LFSR is added, using polynomial x^8+x^6+x^5+x^4+1 and reset to 8'hA5. It advances one step on each accepted request. On acceptance, extra = lfsr[1:0] (value before the step) is added to the wait, so latency becomes LATENCY+extra+1. cnt widens to 5 bits. With LATENCY==0 and extra>0, the block enters WAIT.
- Undefined: no LFSR logic; latency is fixed at LATENCY+1.

Test Plan:
- Reset then idle: hold RST 2 cycles -> req_ready=0 and resp_valid=0 during RST; req_ready=1 in the first cycle after RST falls.
- Write then read, LATENCY=2: write addr 0x10, wdata 0xDEADBEEF, be 4'hF -> resp_valid rises 3 cycles after accept with rdata=0 and err=0. Then read 0x10 -> rdata=0xDEADBEEF.
- Byte enable: word 0x10 holds 0xDEADBEEF; write wdata 0x11223344, be 4'b0101 -> subsequent read returns 0xDE22BE44.
- Errors: read 0x13 -> err=1, rdata=0. Write 0x1000 with DEPTH_WORDS=1024 -> err=1 and the array is unchanged (read 0x0 returns its prior value).
- Response backpressure: hold resp_ready=0 for 5 cycles in RESP -> resp_valid, rdata and err stay stable and req_ready=0. A new req_valid presented during this time is ignored.
- Reset mid-WAIT: accept a write of 0x55AA55AA to 0x20 and assert RST in WAIT -> a later read of 0x20 returns the old value. With RV_MEM_RAND_STALL_EN, the first four latencies after reset match the LFSR sequence from 8'hA5.
